// File: rtl/sram_arb_pkg.sv
// Shared types and default constants for the SRAM port arbiter.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    COMPLETE
  } arb_state_t;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_t;

  localparam int DEF_ADDR_W       = 23;
  localparam int DEF_BUSY_TIMEOUT = 4;
  localparam int DEF_STARVE_LIMIT = 8;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and memory-controller signals shared by the arbiter and its
// environment. The arbiter uses the slave view; the surroundings use master.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [7:0]        a_wdata;
  logic              a_ack;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_wdata;
  logic              b_ack;
  logic [7:0]        b_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic              mem_rd;
  logic [7:0]        mem_dout;
  logic              mem_ready;

  logic              busy;

  modport slave (
    input  a_req, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
           mem_dout, mem_ready,
    output a_ack, b_ack, b_rdata, mem_addr, mem_din, mem_we, mem_rd, busy
  );

  modport master (
    output a_req, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
           mem_dout, mem_ready,
    input  a_ack, b_ack, b_rdata, mem_addr, mem_din, mem_we, mem_rd, busy
  );

endinterface

// File: rtl/sram_arb_grant.sv
// Grant decision: A wins unless B has waited through STARVE_LIMIT A grants.
// Purely combinational; the top registers owner and starve count on grant.
module sram_arb_grant
  import sram_arb_pkg::*;
#(
  parameter  int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int ST_W         = cnt_width(STARVE_LIMIT)
) (
  input  logic            a_req,
  input  logic            b_req,
  input  logic [ST_W-1:0] starve_cnt,
  output owner_t          owner,
  output logic [ST_W-1:0] starve_nxt
);

  // Select owner and compute the starve count that applies after this grant.
  always_comb begin
    owner      = OWN_A;
    starve_nxt = starve_cnt;
    if (b_req && (!a_req || (starve_cnt == ST_W'(STARVE_LIMIT)))) begin
      owner      = OWN_B;
      starve_nxt = '0;
    end else if (b_req) begin
      // a_req is set here and the count is below the limit
      starve_nxt = starve_cnt + ST_W'(1);
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Schedules the single SRAM byte port between the download writer (A) and
// the core bus (B), one access in flight at a time.
//
//  state     | meaning
//  IDLE      | waiting for mem_ready and a request; grant latches the access
//  ISSUE     | one-cycle mem_we/mem_rd strobe, timeout counter loaded
//  WAIT_BUSY | waiting for the controller to drop mem_ready, or timeout
//  WAIT_DONE | waiting for mem_ready to return
//  COMPLETE  | one-cycle ack to the owner
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk_sys,
  input  logic                reset,
  sram_port_arbiter_if.slave  bus
);

  localparam int TO_W = cnt_width(BUSY_TIMEOUT);
  localparam int ST_W = cnt_width(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [ST_W-1:0]   starve_q, starve_d;

  owner_t            gnt_owner;
  logic [ST_W-1:0]   gnt_starve;

  sram_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .a_req      (bus.a_req),
    .b_req      (bus.b_req),
    .starve_cnt (starve_q),
    .owner      (gnt_owner),
    .starve_nxt (gnt_starve)
  );

  // State and access registers; reset aborts any access without an ack.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_B;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
      tmo_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      tmo_q    <= tmo_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic: grant, strobe, wait for the controller, acknowledge.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    tmo_d    = tmo_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_ready && (bus.a_req || bus.b_req)) begin
          owner_d  = gnt_owner;
          starve_d = gnt_starve;
          if (gnt_owner == OWN_A) begin
            addr_d = bus.a_addr;
            din_d  = bus.a_wdata;
            we_d   = 1'b1;
          end else begin
            addr_d = bus.b_addr;
            din_d  = bus.b_wdata;
            we_d   = bus.b_we;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = TO_W'(BUSY_TIMEOUT);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.mem_ready) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == '0) begin
          // controller never showed busy; treat the access as finished
          state_d = COMPLETE;
          if (owner_q == OWN_B && !we_q) rdata_d = bus.mem_dout;
        end else begin
          tmo_d = tmo_q - TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.mem_ready) begin
          state_d = COMPLETE;
          if (owner_q == OWN_B && !we_q) rdata_d = bus.mem_dout;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_we   = (state_q == ISSUE) && we_q;
  assign bus.mem_rd   = (state_q == ISSUE) && !we_q;
  assign bus.a_ack    = (state_q == COMPLETE) && (owner_q == OWN_A);
  assign bus.b_ack    = (state_q == COMPLETE) && (owner_q == OWN_B);
  assign bus.busy     = (state_q != IDLE);
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.b_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small mem_ready controller model.
module tb_sram_port_arbiter;

  localparam int ADDR_W       = 23;
  localparam int BUSY_TIMEOUT = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct {
    logic              a_req;
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    int                busy_n;
    logic [7:0]        dout;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_din;
    logic              exp_b_ack;
    int                exp_lat;
    logic [7:0]        exp_rdata;
  } vec_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    int                cyc;
  } strobe_t;

  typedef struct {
    logic       is_b;
    int         cyc;
    logic [7:0] rdata;
  } ack_t;

  logic clk_sys;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int   busy_cfg = 0;
  int   busy_left = 0;
  int   busy_cnt = 0;
  int   strobe_conflicts = 0;
  int   ack_conflicts = 0;
  strobe_t strobe_q[$];
  ack_t    ack_q[$];
  int   s_base, a_base;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W)) bif ();

  sram_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bif)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Controller model and monitor: drops mem_ready for busy_cfg cycles after
  // each strobe, and logs strobes and acks.
  always @(negedge clk_sys) begin
    if (reset) begin
      bif.mem_ready = 1'b1;
      busy_left     = 0;
    end else begin
      if (busy_left > 0) begin
        busy_left = busy_left - 1;
        if (busy_left == 0) bif.mem_ready = 1'b1;
      end
      if (bif.mem_we || bif.mem_rd) begin
        strobe_q.push_back('{bif.mem_we, bif.mem_addr, bif.mem_din, cyc});
        if (busy_cfg > 0) begin
          bif.mem_ready = 1'b0;
          busy_left     = busy_cfg + 1;
        end
      end
      if (bif.mem_we && bif.mem_rd) strobe_conflicts = strobe_conflicts + 1;
      if (bif.a_ack || bif.b_ack) ack_q.push_back('{bif.b_ack, cyc, bif.b_rdata});
      if (bif.a_ack && bif.b_ack) ack_conflicts = ack_conflicts + 1;
      if (bif.busy) busy_cnt = busy_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  task automatic mark();
    s_base = strobe_q.size();
    a_base = ack_q.size();
  endtask

  // Wait for n new acks; drop each requester on its ack when drop is set.
  task automatic wait_acks(input int n, input int limit, input bit drop);
    for (int i = 0; i < limit && (ack_q.size() - a_base) < n; i++) begin
      step(1);
      if (drop && bif.a_ack) bif.a_req = 1'b0;
      if (drop && bif.b_ack) bif.b_req = 1'b0;
    end
    chk("ack_count", 32'(ack_q.size() - a_base), 32'(n));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    mark();
    busy_cfg     = v.busy_n;
    bif.mem_dout = v.dout;
    if (v.a_req) begin
      bif.a_addr  = v.addr;
      bif.a_wdata = v.wdata;
      bif.a_req   = 1'b1;
    end else begin
      bif.b_addr  = v.addr;
      bif.b_wdata = v.wdata;
      bif.b_we    = v.b_we;
      bif.b_req   = 1'b1;
    end
    wait_acks(1, 80, 1'b1);
    chk({tag, "_strobes"}, 32'(strobe_q.size() - s_base), 32'd1);
    if (strobe_q.size() > s_base) begin
      chk({tag, "_we"}, 32'(strobe_q[s_base].we), 32'(v.exp_we));
      chk({tag, "_addr"}, 32'(strobe_q[s_base].addr), 32'(v.exp_addr));
      if (v.exp_we) chk({tag, "_din"}, 32'(strobe_q[s_base].din), 32'(v.exp_din));
    end
    if (ack_q.size() > a_base && strobe_q.size() > s_base) begin
      chk({tag, "_ack_b"}, 32'(ack_q[a_base].is_b), 32'(v.exp_b_ack));
      chk({tag, "_latency"}, 32'(ack_q[a_base].cyc - strobe_q[s_base].cyc), 32'(v.exp_lat));
      chk({tag, "_rdata"}, 32'(ack_q[a_base].rdata), 32'(v.exp_rdata));
    end
    step(2);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 23'h001234, 8'h00, 5, 8'hA5, 1'b0, 23'h001234, 8'h00, 1'b1, 7, 8'hA5};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 23'h000010, 8'h3C, 0, 8'h00, 1'b1, 23'h000010, 8'h3C, 1'b0, BUSY_TIMEOUT + 2, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 23'h0ABCDE, 8'h5A, 2, 8'h00, 1'b1, 23'h0ABCDE, 8'h5A, 1'b1, 4, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 23'h7FFFFF, 8'h00, 0, 8'h3E, 1'b0, 23'h7FFFFF, 8'h00, 1'b1, 6, 8'h3E};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 23'h000000, 8'hFF, 1, 8'h00, 1'b1, 23'h000000, 8'hFF, 1'b0, 3, 8'h3E};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 23'h000001, 8'h77, 3, 8'h00, 1'b0, 23'h000001, 8'h00, 1'b1, 5, 8'h00};

    reset        = 1'b1;
    bif.a_req    = 1'b0;
    bif.a_addr   = '0;
    bif.a_wdata  = '0;
    bif.b_req    = 1'b0;
    bif.b_we     = 1'b0;
    bif.b_addr   = '0;
    bif.b_wdata  = '0;
    bif.mem_dout = '0;

    step(3);
    chk("reset_ctrl", {27'd0, bif.busy, bif.mem_we, bif.mem_rd, bif.a_ack, bif.b_ack}, 32'd0);
    chk("reset_addr", 32'(bif.mem_addr), 32'd0);
    chk("reset_data", {16'd0, bif.mem_din, bif.b_rdata}, 32'd0);
    reset = 1'b0;
    step(2);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Simultaneous first requests: A strobes first, then B.
    mark();
    busy_cfg    = 1;
    bif.a_addr  = 23'h000200;
    bif.a_wdata = 8'h11;
    bif.b_addr  = 23'h000100;
    bif.b_wdata = 8'h77;
    bif.b_we    = 1'b1;
    bif.a_req   = 1'b1;
    bif.b_req   = 1'b1;
    wait_acks(2, 80, 1'b1);
    chk("simul_strobes", 32'(strobe_q.size() - s_base), 32'd2);
    if (strobe_q.size() >= s_base + 2) begin
      chk("simul_first_addr", 32'(strobe_q[s_base].addr), 32'h200);
      chk("simul_first_din", 32'(strobe_q[s_base].din), 32'h11);
      chk("simul_second_addr", 32'(strobe_q[s_base + 1].addr), 32'h100);
      chk("simul_second_din", 32'(strobe_q[s_base + 1].din), 32'h77);
      chk("simul_second_we", 32'(strobe_q[s_base + 1].we), 32'd1);
    end
    if (ack_q.size() >= a_base + 2) begin
      chk("simul_ack0_b", 32'(ack_q[a_base].is_b), 32'd0);
      chk("simul_ack1_b", 32'(ack_q[a_base + 1].is_b), 32'd1);
    end
    step(2);

    // Both requests held: A x8, B, A x8, B.
    mark();
    busy_cfg     = 1;
    bif.mem_dout = 8'hC3;
    bif.a_addr   = 23'h000300;
    bif.a_wdata  = 8'h01;
    bif.b_addr   = 23'h000400;
    bif.b_we     = 1'b0;
    bif.a_req    = 1'b1;
    bif.b_req    = 1'b1;
    wait_acks(2 * (STARVE_LIMIT + 1), 400, 1'b0);
    bif.a_req = 1'b0;
    bif.b_req = 1'b0;
    chk("starve_strobes", 32'(strobe_q.size() - s_base), 32'(2 * (STARVE_LIMIT + 1)));
    for (int i = 0; i < 2 * (STARVE_LIMIT + 1); i++) begin
      if (ack_q.size() > a_base + i)
        chk($sformatf("starve_order%0d", i), 32'(ack_q[a_base + i].is_b),
            32'((i == STARVE_LIMIT) || (i == 2 * STARVE_LIMIT + 1)));
      if (strobe_q.size() > s_base + i)
        chk($sformatf("starve_kind%0d", i), 32'(strobe_q[s_base + i].we),
            32'(!((i == STARVE_LIMIT) || (i == 2 * STARVE_LIMIT + 1))));
    end
    step(1);
    chk("starve_rdata", 32'(bif.b_rdata), 32'hC3);
    step(2);

    // Reset during WAIT_DONE of a B read.
    mark();
    busy_cfg     = 20;
    bif.mem_dout = 8'h99;
    bif.b_addr   = 23'h000055;
    bif.b_we     = 1'b0;
    bif.b_req    = 1'b1;
    for (int i = 0; i < 20 && strobe_q.size() == s_base; i++) step(1);
    chk("abort_strobe_seen", 32'(strobe_q.size() - s_base), 32'd1);
    step(3);
    chk("abort_in_wait", {31'd0, bif.busy}, 32'd1);
    reset = 1'b1;
    step(1);
    chk("abort_ctrl", {27'd0, bif.busy, bif.mem_we, bif.mem_rd, bif.a_ack, bif.b_ack}, 32'd0);
    chk("abort_addr", 32'(bif.mem_addr), 32'd0);
    chk("abort_data", {16'd0, bif.mem_din, bif.b_rdata}, 32'd0);
    step(2);
    reset = 1'b0;
    chk("abort_no_ack", 32'(ack_q.size() - a_base), 32'd0);
    mark();
    busy_cfg = 2;
    wait_acks(1, 40, 1'b1);
    chk("regrant_strobes", 32'(strobe_q.size() - s_base), 32'd1);
    if (strobe_q.size() > s_base) chk("regrant_addr", 32'(strobe_q[s_base].addr), 32'h55);
    if (ack_q.size() > a_base) begin
      chk("regrant_ack_b", 32'(ack_q[a_base].is_b), 32'd1);
      chk("regrant_rdata", 32'(ack_q[a_base].rdata), 32'h99);
    end
    step(2);

    // Idle for 100 cycles.
    mark();
    busy_cnt = 0;
    step(100);
    chk("idle_strobes", 32'(strobe_q.size() - s_base), 32'd0);
    chk("idle_busy", 32'(busy_cnt), 32'd0);

    chk("strobe_exclusive", 32'(strobe_conflicts), 32'd0);
    chk("ack_exclusive", 32'(ack_conflicts), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
